ad5322_dac_writer: RTL

//  SPI transmitter for a dual 12-bit DAC (AD5322-class: 16-bit word, SYNC/SCLK/DIN, LDAC).

---
 rtl/ad5322_dac_writer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ad5322_dac_writer.sv
// Dual-channel AD5322-class SPI writer: saturates two signed 13-bit samples to 12-bit
// offset binary, shifts word A then word B, then strobes LDAC so both outputs update together.
module ad5322_dac_writer #(
  parameter int SCLK_HALF  = 2,
  parameter int SYNC_GAP   = 2,
  parameter int LDAC_WIDTH = 2,
  parameter bit BUF        = 1'b0
) (
  input  logic        clk20MHz,
  input  logic        rst,
  input  logic [12:0] data_a,
  input  logic [12:0] data_b,
  input  logic [1:0]  pd_mode,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic        sat_a,
  output logic        sat_b,
  output logic        SYNC,
  output logic        SCLK,
  output logic        DIN,
  output logic        LDAC
);
  localparam int PW   = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int CMAX = (SYNC_GAP > LDAC_WIDTH) ? SYNC_GAP : LDAC_WIDTH;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SYNC_GAP - 1);
  localparam logic [CW-1:0] LD_LAST  = CW'(LDAC_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_A, GAP_A, SHIFT_B, GAP_B, LDAC_LO, DONE} state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic        hf_q, hf_d;
  logic [3:0]  bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] word_a_q, word_a_d, word_b_q, word_b_d;
  logic        sat_a_q, sat_a_d, sat_b_q, sat_b_d;
  logic        sync_q, sync_d, sclk_q, sclk_d, din_q, din_d;
  logic        ldac_q, ldac_d, busy_q, busy_d, done_q, done_d;
  logic [12:0] cv_a, cv_b;
  logic        shift_d;
  logic [15:0] sel_word;

  // {clamped, offset-binary code}
  function automatic logic [12:0] sat_code(input logic signed [12:0] s);
    if (s > 13'sd2047)        return {1'b1, 12'hFFF};
    else if (s < -13'sd2048)  return {1'b1, 12'h000};
    else                      return {1'b0, ~s[11], s[10:0]};
  endfunction

  assign cv_a = sat_code(data_a);
  assign cv_b = sat_code(data_b);

  always_ff @(posedge clk20MHz or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      hf_q     <= 1'b0;
      bit_q    <= '0;
      cnt_q    <= '0;
      word_a_q <= '0;
      word_b_q <= '0;
      sat_a_q  <= 1'b0;
      sat_b_q  <= 1'b0;
      sync_q   <= 1'b1;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
      ldac_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      hf_q     <= hf_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      word_a_q <= word_a_d;
      word_b_q <= word_b_d;
      sat_a_q  <= sat_a_d;
      sat_b_q  <= sat_b_d;
      sync_q   <= sync_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
      ldac_q   <= ldac_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    hf_d     = hf_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    word_a_d = word_a_q;
    word_b_d = word_b_q;
    sat_a_d  = sat_a_q;
    sat_b_d  = sat_b_q;
    case (state_q)
      IDLE: if (load) begin
        state_d  = SHIFT_A;
        word_a_d = {1'b0, BUF, pd_mode, cv_a[11:0]};
        word_b_d = {1'b1, BUF, pd_mode, cv_b[11:0]};
        sat_a_d  = cv_a[12];
        sat_b_d  = cv_b[12];
        ph_d     = '0;
        hf_d     = 1'b0;
        bit_d    = '0;
      end
      SHIFT_A, SHIFT_B: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (!hf_q) hf_d = 1'b1;
          else begin
            hf_d = 1'b0;
            if (bit_q == 4'd15) begin
              state_d = (state_q == SHIFT_A) ? GAP_A : GAP_B;
              cnt_d   = '0;
            end else bit_d = bit_q + 4'd1;
          end
        end else ph_d = ph_q + PW'(1);
      end
      GAP_A: begin
        if (cnt_q == GAP_LAST) begin
          state_d = SHIFT_B;
          ph_d    = '0;
          hf_d    = 1'b0;
          bit_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      GAP_B: begin
        if (cnt_q == GAP_LAST) begin
          state_d = LDAC_LO;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      LDAC_LO: if (cnt_q == LD_LAST) state_d = DONE;
               else cnt_d = cnt_q + CW'(1);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so every pin comes straight off a flop.
  always_comb begin
    shift_d  = (state_d == SHIFT_A) || (state_d == SHIFT_B);
    sel_word = (state_d == SHIFT_A) ? word_a_d : word_b_d;
    sync_d   = !shift_d;
    sclk_d   = shift_d ? !hf_d : 1'b1;
    din_d    = shift_d ? sel_word[~bit_d] : 1'b0;
    ldac_d   = (state_d != LDAC_LO);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sat_a = sat_a_q;
  assign sat_b = sat_b_q;
  assign SYNC  = sync_q;
  assign SCLK  = sclk_q;
  assign DIN   = din_q;
  assign LDAC  = ldac_q;
endmodule
